// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI-Lite write-address arbiter.
package axil_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } arbState_t;

   function automatic int calcIdw(input int numReq);
      return (numReq < 2) ? 1 : $clog2(numReq);
   endfunction

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational round-robin picker: the winner is the requester closest
// above lastGrant, wrapping around, so lastGrant itself is served last.
module axil_rr_pick
   import axil_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDW     = calcIdw(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_lastGrant,
   output logic               o_valid,
   output logic [IDW-1:0]     o_winner
);

   int w_dist;
   int w_bestDist;

   // Distance 0 is the slot just after lastGrant; the smallest distance wins.
   always_comb begin
      o_valid    = 1'b0;
      o_winner   = '0;
      w_dist     = 0;
      w_bestDist = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_dist = (i + NUM_REQ - 1 - int'(i_lastGrant)) % NUM_REQ;
         if (i_req[i] && (w_dist < w_bestDist)) begin
            w_bestDist = w_dist;
            o_valid    = 1'b1;
            o_winner   = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/axil_aw_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite write-address channel among NUM_REQ requesters.
// Define AXIL_AW_TIMEOUT_EN to build the AWREADY wait-limit counter driving timeout_err.
module axil_aw_arbiter
   import axil_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   parameter  int ADDR_W  = 32,
   parameter  int MAXWAIT = 5,
   localparam int IDW     = calcIdw(NUM_REQ)
) (
   input  logic                      AXI_ACLK,
   input  logic                      AXI_ARESET,
   input  logic [NUM_REQ-1:0]        req_awvalid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_awaddr,
   output logic [NUM_REQ-1:0]        req_awready,
   output logic [ADDR_W-1:0]         AXI_AWADDR,
   output logic                      AXI_AWVALID,
   input  logic                      AXI_AWREADY,
   output logic [IDW-1:0]            grant_id,
   output logic                      timeout_err
);

   arbState_t         r_state;
   arbState_t         w_nextState;
   logic [IDW-1:0]    r_lastGrant;
   logic [IDW-1:0]    r_grantId;
   logic [ADDR_W-1:0] r_awaddr;
   logic [IDW-1:0]    w_winner;
   logic [ADDR_W-1:0] w_winAddr;
   logic              w_pickValid;
   logic              w_grant;

   axil_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req       (req_awvalid),
      .i_lastGrant (r_lastGrant),
      .o_valid     (w_pickValid),
      .o_winner    (w_winner)
   );

   always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
      if (AXI_ARESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_pickValid) w_nextState = ISSUE;
         ISSUE:   if (AXI_AWREADY) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // The grant is acknowledged in the same IDLE cycle; ISSUE never acknowledges.
   always_comb begin
      AXI_AWVALID = (r_state == ISSUE);
      w_grant     = (r_state == IDLE) && w_pickValid;
      req_awready = '0;
      if (w_grant) begin
         req_awready[w_winner] = 1'b1;
      end
   end

   always_comb begin
      w_winAddr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winner == IDW'(i)) begin
            w_winAddr = req_awaddr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Address and id only load on a grant, so they hold through ISSUE and linger in IDLE.
   always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
      if (AXI_ARESET) begin
         r_awaddr    <= '0;
         r_grantId   <= '0;
         r_lastGrant <= IDW'(NUM_REQ - 1);
      end else if (w_grant) begin
         r_awaddr    <= w_winAddr;
         r_grantId   <= w_winner;
         r_lastGrant <= w_winner;
      end
   end

   assign AXI_AWADDR = r_awaddr;
   assign grant_id   = r_grantId;

`ifdef AXIL_AW_TIMEOUT_EN
   localparam int CNTW = $clog2(MAXWAIT + 1);

   logic [CNTW-1:0] r_waitCnt;

   // Saturating at MAXWAIT keeps the error to a single pulse per transfer.
   always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
      if (AXI_ARESET) begin
         r_waitCnt <= '0;
      end else if (w_grant) begin
         r_waitCnt <= '0;
      end else if ((r_state == ISSUE) && !AXI_AWREADY && (r_waitCnt != CNTW'(MAXWAIT))) begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   assign timeout_err = (r_state == ISSUE) && !AXI_AWREADY && (r_waitCnt == CNTW'(MAXWAIT - 1));
`else
   // MAXWAIT only matters when the counter is built; the term is always false here.
   assign timeout_err = 1'b0 & (MAXWAIT < 0);
`endif

endmodule

// File: doc/axil_aw_arbiter.md
AXIL_AW_ARBITER -- requirements
Module: axil_aw_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing one AXI-Lite write-address port (legal range 2..8).
REQ-002 Parameter ADDR_W, default 32, SHALL set the AWADDR width.
REQ-003 Parameter MAXWAIT, default 5, SHALL set the AWREADY wait limit in cycles for the timeout check.
REQ-004 AXI_ACLK  in  1  the single clock; all logic SHALL sample on its rising edge.
REQ-005 AXI_ARESET  in  1  reset; asynchronous, active-high.
REQ-006 req_awvalid  in  NUM_REQ  per-requester address-valid.
REQ-007 req_awaddr  in  NUM_REQ*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 req_awready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 AXI_AWADDR  out  ADDR_W  shared address to the slave.
REQ-010 AXI_AWVALID  out  1  shared valid to the slave.
REQ-011 AXI_AWREADY  in  1  slave ready.
REQ-012 grant_id  out  IDW  index of the requester whose address is on AXI_AWADDR; IDW = $clog2(NUM_REQ).
REQ-013 timeout_err  out  1  one-cycle pulse on a wait-limit violation.

Function
REQ-014 FSM SHALL have two states: IDLE (AXI_AWVALID=0) and ISSUE (AXI_AWVALID=1).
REQ-015 IDLE with any req_awvalid bit set SHALL pick one winner by round-robin, assert req_awready[winner] combinationally in that cycle, register its address into AXI_AWADDR and its index into grant_id, and move to ISSUE.
REQ-016 Round-robin priority SHALL start at index (last_grant+1) mod NUM_REQ and ascend with wrap; last_grant SHALL update only on a grant.
REQ-017 Latency from req_awvalid (arbiter in IDLE) to AXI_AWVALID SHALL be exactly 1 cycle.
REQ-018 In ISSUE, AXI_AWADDR, grant_id and AXI_AWVALID SHALL hold stable until AXI_AWREADY is sampled high.
REQ-019 ISSUE with AXI_AWREADY=1 SHALL return to IDLE; AXI_AWVALID SHALL be 0 the following cycle (minimum 2 cycles per transfer, no back-to-back issue).
REQ-020 req_awready SHALL be all-zero in ISSUE and in IDLE with no request.
REQ-021 Simultaneous requests SHALL produce exactly one grant; losers' requests remain pending and are not acknowledged.
REQ-022 A requester deasserting req_awvalid before its grant SHALL be dropped without side effects.
REQ-023 AXI_AWADDR SHALL keep its last value in IDLE (no X, no forced zero).

Reset
REQ-024 Asserting AXI_ARESET at any time, including mid-ISSUE, SHALL force IDLE, AXI_AWVALID=0, AXI_AWADDR=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 highest priority first), timeout counter=0, timeout_err=0.
REQ-025 The first grant SHALL be possible in the first cycle after AXI_ARESET deasserts.

Configuration
REQ-026 Macro AXIL_AW_TIMEOUT_EN defined: a counter SHALL count ISSUE cycles with AXI_AWREADY low, clear on entry to ISSUE, and pulse timeout_err for one cycle when it reaches MAXWAIT; the FSM SHALL stay in ISSUE with outputs stable (no abort), and no further pulse SHALL occur for that transfer.
REQ-027 Macro undefined: no counter SHALL be built and timeout_err SHALL be tied to 0.

Structure
REQ-028 Package axil_arb_pkg SHALL hold the FSM state enum (IDLE, ISSUE) and the IDW computation function.
REQ-029 Round-robin selection SHALL live in one combinational sub-module axil_rr_pick (inputs request vector, last_grant; outputs valid, winner index).

Verification
REQ-030 Single request: reset, req_awvalid=2'b01, addr0=0x1000, AWREADY=1 -> req_awready=2'b01 at cycle 0; AXI_AWVALID=1, AXI_AWADDR=0x1000, grant_id=0 at cycle 1; AXI_AWVALID=0 at cycle 2.
REQ-031 Contention: both requesting continuously, addr0=0xA0, addr1=0xB0, AWREADY=1 -> AXI_AWADDR sequence 0xA0, 0xB0, 0xA0, 0xB0.
REQ-032 Backpressure: grant addr 0x44, AWREADY low 3 cycles -> AXI_AWVALID and AXI_AWADDR=0x44 stable 4 cycles, handshake on 4th, no req_awready during ISSUE.
REQ-033 Timeout (macro defined, MAXWAIT=5): AWREADY held low 8 cycles -> single timeout_err pulse in the 5th low ISSUE cycle, AXI_AWVALID stays 1; macro undefined -> timeout_err never 1.
REQ-034 Reset mid-ISSUE: assert AXI_ARESET asynchronously while AXI_AWVALID=1 -> AXI_AWVALID=0 before the next clock edge; after release with both requesting, requester 0 granted first.
